// File: rtl/fetch_redirect_unit.sv
// Fetch-stage PC register, IF/ID pipeline registers and EX-resolved redirect.
// A branch/jump in EX whose resolved next-PC differs from the fetch-time prediction flushes IF/ID.
module fetch_redirect_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,

  output logic [31:0] current_pc,
  input  logic [31:0] btb_next_pc,
  input  logic        predict_branch_taken,
  input  logic [31:0] imem_inst,

  input  logic        pc_write,
  input  logic        IF_ID_write,

  input  logic        ID_EX_valid,
  input  logic        ID_EX_is_branch,
  input  logic        ID_EX_is_jal,
  input  logic        ID_EX_is_jalr,
  input  logic        ID_EX_actual_branch_taken,
  input  logic [31:0] ID_EX_pc,
  input  logic [31:0] ID_EX_branch_target,
  input  logic [31:0] ID_EX_predicted_pc,
  input  logic        ex_fire,

  output logic [31:0] IF_ID_inst,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_predicted_pc,
  output logic        IF_ID_predicted_taken,
  output logic        IF_ID_valid,

  output logic        mispredict,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  logic        ex_ctrl;
  logic        ex_redirect_taken;
  logic [31:0] ex_fallthrough_pc;
  logic [31:0] correct_pc;

  logic [31:0] pc_q, pc_d;
  logic [31:0] if_id_inst_q, if_id_inst_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pred_pc_q, if_id_pred_pc_d;
  logic        if_id_pred_taken_q, if_id_pred_taken_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] branch_count_q, branch_count_d;
  logic [31:0] mispredict_count_q, mispredict_count_d;

  // EX resolution: gating on ID_EX_valid keeps bubbles from ever redirecting.
  assign ex_ctrl           = ID_EX_valid & (ID_EX_is_branch | ID_EX_is_jal | ID_EX_is_jalr);
  assign ex_redirect_taken = ID_EX_is_jal | ID_EX_is_jalr | ID_EX_actual_branch_taken;
  assign ex_fallthrough_pc = ID_EX_pc + 32'd4;
  assign correct_pc        = ex_redirect_taken ? ID_EX_branch_target : ex_fallthrough_pc;
  assign mispredict        = ex_ctrl & (correct_pc != ID_EX_predicted_pc);

  always_comb begin
    pc_d = pc_q;
    if (mispredict) begin
      pc_d = align_pc(correct_pc);
    end else if (pc_write) begin
      pc_d = align_pc(btb_next_pc);
    end
  end

  // A flush wins over an IF/ID stall so the wrong-path instruction cannot linger.
  always_comb begin
    if_id_inst_d       = if_id_inst_q;
    if_id_pc_d         = if_id_pc_q;
    if_id_pred_pc_d    = if_id_pred_pc_q;
    if_id_pred_taken_d = if_id_pred_taken_q;
    if_id_valid_d      = if_id_valid_q;
    if (mispredict) begin
      if_id_inst_d  = NOP_INST;
      if_id_valid_d = 1'b0;
    end else if (IF_ID_write) begin
      if_id_inst_d       = imem_inst;
      if_id_pc_d         = pc_q;
      if_id_pred_pc_d    = btb_next_pc;
      if_id_pred_taken_d = predict_branch_taken;
      if_id_valid_d      = 1'b1;
    end
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (ex_ctrl && ex_fire) begin
      branch_count_d = sat_inc(branch_count_q);
    end
    if (mispredict && ex_fire) begin
      mispredict_count_d = sat_inc(mispredict_count_q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q               <= RESET_PC;
      if_id_inst_q       <= NOP_INST;
      if_id_pc_q         <= 32'h0000_0000;
      if_id_pred_pc_q    <= 32'h0000_0000;
      if_id_pred_taken_q <= 1'b0;
      if_id_valid_q      <= 1'b0;
      branch_count_q     <= 32'h0000_0000;
      mispredict_count_q <= 32'h0000_0000;
    end else begin
      pc_q               <= pc_d;
      if_id_inst_q       <= if_id_inst_d;
      if_id_pc_q         <= if_id_pc_d;
      if_id_pred_pc_q    <= if_id_pred_pc_d;
      if_id_pred_taken_q <= if_id_pred_taken_d;
      if_id_valid_q      <= if_id_valid_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign current_pc            = pc_q;
  assign IF_ID_inst            = if_id_inst_q;
  assign IF_ID_pc              = if_id_pc_q;
  assign IF_ID_predicted_pc    = if_id_pred_pc_q;
  assign IF_ID_predicted_taken = if_id_pred_taken_q;
  assign IF_ID_valid           = if_id_valid_q;
  assign branch_count          = branch_count_q;
  assign mispredict_count      = mispredict_count_q;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit: sequential fetch, redirects, stalls,
// alignment, PC wrap, counter saturation and asynchronous reset.
module tb_fetch_redirect_unit;

  logic        clk;
  logic        reset;
  logic [31:0] current_pc;
  logic [31:0] btb_next_pc;
  logic        predict_branch_taken;
  logic [31:0] imem_inst;
  logic        pc_write;
  logic        IF_ID_write;
  logic        ID_EX_valid;
  logic        ID_EX_is_branch;
  logic        ID_EX_is_jal;
  logic        ID_EX_is_jalr;
  logic        ID_EX_actual_branch_taken;
  logic [31:0] ID_EX_pc;
  logic [31:0] ID_EX_branch_target;
  logic [31:0] ID_EX_predicted_pc;
  logic        ex_fire;
  logic [31:0] IF_ID_inst;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_predicted_pc;
  logic        IF_ID_predicted_taken;
  logic        IF_ID_valid;
  logic        mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int total = 0;
  int bad   = 0;

  fetch_redirect_unit dut (
    .clk                       (clk),
    .reset                     (reset),
    .current_pc                (current_pc),
    .btb_next_pc               (btb_next_pc),
    .predict_branch_taken      (predict_branch_taken),
    .imem_inst                 (imem_inst),
    .pc_write                  (pc_write),
    .IF_ID_write               (IF_ID_write),
    .ID_EX_valid               (ID_EX_valid),
    .ID_EX_is_branch           (ID_EX_is_branch),
    .ID_EX_is_jal              (ID_EX_is_jal),
    .ID_EX_is_jalr             (ID_EX_is_jalr),
    .ID_EX_actual_branch_taken (ID_EX_actual_branch_taken),
    .ID_EX_pc                  (ID_EX_pc),
    .ID_EX_branch_target       (ID_EX_branch_target),
    .ID_EX_predicted_pc        (ID_EX_predicted_pc),
    .ex_fire                   (ex_fire),
    .IF_ID_inst                (IF_ID_inst),
    .IF_ID_pc                  (IF_ID_pc),
    .IF_ID_predicted_pc        (IF_ID_predicted_pc),
    .IF_ID_predicted_taken     (IF_ID_predicted_taken),
    .IF_ID_valid               (IF_ID_valid),
    .mispredict                (mispredict),
    .branch_count              (branch_count),
    .mispredict_count          (mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic br, input logic jal, input logic jalr,
                        input logic tk, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic [31:0] pred, input logic fire);
    ID_EX_valid               = v;
    ID_EX_is_branch           = br;
    ID_EX_is_jal              = jal;
    ID_EX_is_jalr             = jalr;
    ID_EX_actual_branch_taken = tk;
    ID_EX_pc                  = pc;
    ID_EX_branch_target       = tgt;
    ID_EX_predicted_pc        = pred;
    ex_fire                   = fire;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_pc"},       current_pc, 32'h0);
    chk({tag, "_inst"},     IF_ID_inst, 32'h0000_0013);
    chk({tag, "_ifid_pc"},  IF_ID_pc, 32'h0);
    chk({tag, "_pred_pc"},  IF_ID_predicted_pc, 32'h0);
    chk({tag, "_pred_tk"},  {31'd0, IF_ID_predicted_taken}, 32'h0);
    chk({tag, "_valid"},    {31'd0, IF_ID_valid}, 32'h0);
    chk({tag, "_bcnt"},     branch_count, 32'h0);
    chk({tag, "_mcnt"},     mispredict_count, 32'h0);
  endtask

  initial begin
    reset                = 1'b0;
    btb_next_pc          = 32'h0;
    predict_branch_taken = 1'b0;
    imem_inst            = 32'h0;
    pc_write             = 1'b0;
    IF_ID_write          = 1'b0;
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    #12;
    chk_reset_state("rst");

    // Invalid EX content that would otherwise mispredict
    set_ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h80, 32'h44, 1'b1);
    #1;
    chk("invalid_no_redirect", {31'd0, mispredict}, 32'h0);
    step();
    chk("invalid_no_bcnt", branch_count, 32'h0);
    chk("invalid_pc_hold", current_pc, 32'h0);
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);

    // Sequential fetch 0,4,8,C
    reset       = 1'b1;
    pc_write    = 1'b1;
    IF_ID_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq_pc%0d", i), current_pc, 32'(4 * i));
      if (i > 0) begin
        chk($sformatf("seq_ifid_pc%0d", i), IF_ID_pc, 32'(4 * (i - 1)));
        chk($sformatf("seq_ifid_inst%0d", i), IF_ID_inst, 32'hA000_0000 | 32'(4 * (i - 1)));
        chk($sformatf("seq_valid%0d", i), {31'd0, IF_ID_valid}, 32'h1);
      end
      btb_next_pc = current_pc + 32'd4;
      imem_inst   = 32'hA000_0000 | current_pc;
      if (i < 3) step();
    end

    // Taken branch at 0x40 predicted not-taken
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h80, 32'h44, 1'b1);
    #1;
    chk("br_mis_comb", {31'd0, mispredict}, 32'h1);
    step();
    chk("br_mis_pc", current_pc, 32'h80);
    chk("br_mis_valid", {31'd0, IF_ID_valid}, 32'h0);
    chk("br_mis_inst", IF_ID_inst, 32'h0000_0013);
    chk("br_mis_ifid_pc_hold", IF_ID_pc, 32'h8);
    chk("br_mis_bcnt", branch_count, 32'h1);
    chk("br_mis_mcnt", mispredict_count, 32'h1);

    // Same branch correctly predicted
    ID_EX_predicted_pc = 32'h80;
    btb_next_pc        = 32'h84;
    imem_inst          = 32'hB000_0080;
    #1;
    chk("br_ok_comb", {31'd0, mispredict}, 32'h0);
    step();
    chk("br_ok_pc", current_pc, 32'h84);
    chk("br_ok_ifid_pc", IF_ID_pc, 32'h80);
    chk("br_ok_valid", {31'd0, IF_ID_valid}, 32'h1);
    chk("br_ok_bcnt", branch_count, 32'h2);
    chk("br_ok_mcnt", mispredict_count, 32'h1);

    // Not-taken branch: correct prediction, then misprediction without ex_fire
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h80, 32'h44, 1'b0);
    #1;
    chk("nt_ok_comb", {31'd0, mispredict}, 32'h0);
    ID_EX_predicted_pc = 32'h80;
    #1;
    chk("nt_mis_comb", {31'd0, mispredict}, 32'h1);
    step();
    chk("nt_mis_pc", current_pc, 32'h44);
    chk("nt_nofire_bcnt", branch_count, 32'h2);
    chk("nt_nofire_mcnt", mispredict_count, 32'h1);

    // Redirect overrides both stalls
    pc_write    = 1'b0;
    IF_ID_write = 1'b0;
    set_ex(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h200, 32'h104, 1'b1);
    step();
    chk("jal_stall_pc", current_pc, 32'h200);
    chk("jal_stall_valid", {31'd0, IF_ID_valid}, 32'h0);
    chk("jal_stall_ifid_pc", IF_ID_pc, 32'h80);
    chk("jal_bcnt", branch_count, 32'h3);
    chk("jal_mcnt", mispredict_count, 32'h2);
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    step();
    chk("stall_pc_hold", current_pc, 32'h200);
    chk("stall_ifid_hold", IF_ID_pc, 32'h80);

    // jalr to a misaligned target
    set_ex(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h103, 32'h104, 1'b1);
    #1;
    chk("jalr_comb", {31'd0, mispredict}, 32'h1);
    step();
    chk("jalr_align_pc", current_pc, 32'h100);
    chk("jalr_bcnt", branch_count, 32'h4);
    chk("jalr_mcnt", mispredict_count, 32'h3);

    // PC wrap
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    pc_write    = 1'b1;
    btb_next_pc = 32'hFFFF_FFFE;
    step();
    chk("wrap_btb_pc", current_pc, 32'hFFFF_FFFC);
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h80, 32'h8, 1'b0);
    btb_next_pc = 32'h8;
    #1;
    chk("wrap_comb", {31'd0, mispredict}, 32'h1);
    step();
    chk("wrap_fallthrough_pc", current_pc, 32'h0);

    // Counter saturation
    @(negedge clk);
    force dut.branch_count_q     = 32'hFFFF_FFFE;
    force dut.mispredict_count_q = 32'hFFFF_FFFE;
    #1;
    release dut.branch_count_q;
    release dut.mispredict_count_q;
    set_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h80, 32'h44, 1'b1);
    step();
    chk("sat_bcnt_top", branch_count, 32'hFFFF_FFFF);
    chk("sat_mcnt_top", mispredict_count, 32'hFFFF_FFFF);
    step();
    chk("sat_bcnt_hold", branch_count, 32'hFFFF_FFFF);
    chk("sat_mcnt_hold", mispredict_count, 32'hFFFF_FFFF);

    // Asynchronous reset mid-stall with a redirect pending
    pc_write    = 1'b0;
    IF_ID_write = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("async");
    set_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    pc_write             = 1'b1;
    IF_ID_write          = 1'b1;
    btb_next_pc          = 32'h10;
    imem_inst            = 32'h1234_5678;
    predict_branch_taken = 1'b1;
    reset                = 1'b1;
    step();
    chk("post_rst_pc", current_pc, 32'h10);
    chk("post_rst_ifid_pc", IF_ID_pc, 32'h0);
    chk("post_rst_inst", IF_ID_inst, 32'h1234_5678);
    chk("post_rst_pred_pc", IF_ID_predicted_pc, 32'h10);
    chk("post_rst_pred_tk", {31'd0, IF_ID_predicted_taken}, 32'h1);
    chk("post_rst_valid", {31'd0, IF_ID_valid}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
